// File: rtl/uart_tx_scheduler.sv
// Byte FIFO that feeds uart_tx one frame at a time, with an optional idle gap between frames.
// Define UART_TX_SCHED_OVERFLOW_EN to build the sticky overflow flag and its clear input.
module uart_tx_scheduler #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  clr_overflow,
  input  logic                  tx_busy,
  output logic                  tx_en,
  output logic [7:0]            tx_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [7:0]            GAP_LOAD = 8'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, LAUNCH, HOLD, WAIT_DONE, GAP} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [7:0]            gap_q, gap_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_en_q, tx_en_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  full_w, push, pop;

  // Full is judged on the registered level, so a pop in the same cycle never rescues a push.
  assign full_w = (level_q == LVL_FULL);
  assign push   = wr_en && !full_w && !flush;
  assign pop    = (state_q == IDLE) && (level_q != '0) && !flush;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    level_d = level_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d   = LAUNCH;
          tx_data_d = mem_q[rptr_q];
        end
      end
      LAUNCH:    state_d = HOLD;
      // Busy from uart_tx lags the launch by a cycle, so HOLD does not look at it.
      HOLD:      state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd1) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
    tx_en_d = (state_d == LAUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rptr_q    <= '0;
      wptr_q    <= '0;
      level_q   <= '0;
      gap_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      level_q   <= level_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

`ifdef UART_TX_SCHED_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (wr_en && full_w && !flush) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  logic unused_clr_overflow;
  assign unused_clr_overflow = clr_overflow;
  assign overflow = 1'b0;
`endif

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign full    = full_w;
  assign empty   = (level_q == '0);
  assign level   = level_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a queue-based reference model predicts status and launches.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int unsigned DL    = 3;
  localparam int unsigned G     = 3;
  localparam int unsigned DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, flush, clr_overflow, tx_busy;
  logic [7:0]    wr_data;
  logic          tx_en, full, empty, overflow;
  logic [7:0]    tx_data;
  logic [DL:0]   level;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.DEPTH_LOG2(DL), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_overflow(clr_overflow), .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  typedef struct { int cyc; int lvl; int fl; int em; int ovf; int ten; int data; } stat_t;
  typedef struct { int cyc; int data; } launch_t;

  stat_t   stat_q[$];
  launch_t launch_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: queued bytes, sticky flag, time of the last launch and when the
  // scheduler may next pop.
  int  fifo[$];
  bit  m_ovf = 0;
  bit  in_flight = 0;
  int  last_l = -100;
  int  idle_from = 0;
  int  exp_data = 0;
  int  bdelay = 1;
  int  blen = 0;
  int  force_blen = 0;
  bit  stuck = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_busy(input int c);
    return stuck || (c >= last_l + bdelay && c < last_l + bdelay + blen);
  endfunction

  task automatic step(input bit wr, input logic [7:0] d, input bit fl, input bit clr);
    bit busy, was_full, pop;
    stat_t s;
    @(posedge clk); #1;
    cyc++;
    busy = model_busy(cyc);
    wr_en = wr; wr_data = d; flush = fl; clr_overflow = clr; tx_busy = busy;
    s.cyc = cyc; s.lvl = fifo.size(); s.fl = int'(fifo.size() == DEPTH);
    s.em = int'(fifo.size() == 0); s.ovf = m_ovf; s.ten = int'(cyc == last_l); s.data = exp_data;
    stat_q.push_back(s);
    was_full = (fifo.size() == DEPTH);
    pop = !in_flight && cyc >= idle_from && fifo.size() > 0 && !fl;
    if (in_flight && cyc >= last_l + 2 && !busy) begin
      in_flight = 0;
      idle_from = cyc + 1 + G;
    end
`ifdef UART_TX_SCHED_OVERFLOW_EN
    if (wr && was_full && !fl) m_ovf = 1;
    else if (clr)              m_ovf = 0;
`endif
    if (fl) begin
      fifo.delete();
    end else begin
      if (pop) begin
        exp_data  = fifo.pop_front();
        last_l    = cyc + 1;
        in_flight = 1;
        bdelay    = (force_blen != 0) ? 1 : $urandom_range(1, 2);
        blen      = (force_blen != 0) ? force_blen : $urandom_range(1, 12);
        launch_q.push_back('{cyc + 1, exp_data});
      end
      if (wr && !was_full) fifo.push_back(int'(d));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 8'h00, 0, 0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((fifo.size() > 0 || in_flight || cyc < idle_from) && guard < 600) begin
      idle(1);
      guard++;
    end
    if (guard >= 600) chk("drain_timeout", 1, 0);
    idle(3);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_tx_en"}, int'(tx_en), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    wr_en = 0; flush = 0; clr_overflow = 0; tx_busy = 0;
    #1 rst_n = 0;
    stat_q.delete();
    launch_q.delete();
    #1 reset_checks("midrst");
    @(posedge clk); #2 rst_n = 1;
    cyc++;
    fifo.delete();
    m_ovf = 0; in_flight = 0; last_l = -100; idle_from = 0; exp_data = 0; blen = 0;
  endtask

  // Monitor: compares every cycle's status and each tx_en pulse against the queued expectations.
  initial begin
    stat_t   s;
    launch_t lr;
    forever begin
      @(negedge clk);
      if (rst_n && stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("level", int'(level), s.lvl);
        chk("full", int'(full), s.fl);
        chk("empty", int'(empty), s.em);
        chk("overflow", int'(overflow), s.ovf);
        chk("tx_en", int'(tx_en), s.ten);
        chk("tx_data", int'(tx_data), s.data);
      end
      if (rst_n && tx_en === 1'b1) begin
        if (launch_q.size() == 0) chk("spurious_tx_en", 1, 0);
        else begin
          lr = launch_q.pop_front();
          chk("launch_cycle", cyc, lr.cyc);
          chk("launch_data", int'(tx_data), lr.data);
        end
      end
    end
  end

  initial begin
    int guard;
    rst_n = 0; wr_en = 0; wr_data = 0; flush = 0; clr_overflow = 0; tx_busy = 0;
    @(posedge clk); #2 reset_checks("rst");
    @(posedge clk); #2 rst_n = 1;

    // single byte, 10 cycles of busy
    force_blen = 10;
    step(1, 8'h41, 0, 0);
    drain();
    force_blen = 0;

    // ordering and pointer wrap, paced
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 0, 0);
      idle($urandom_range(12, 20));
    end
    drain();

    // overflow with the transmitter held busy
    stuck = 1;
    for (int i = 0; i < 10; i++) step(1, 8'hA0 + 8'(i), 0, 0);
    idle(2);
    step(0, 8'h00, 0, 1);
    idle(2);

    // push while full across the pop cycle
    stuck = 0;
    for (int i = 0; i < 12; i++) step(1, 8'hB0 + 8'(i), 0, 0);
    step(0, 8'h00, 0, 1);
    drain();

    // flush while the first byte is in WAIT_DONE
    force_blen = 8;
    for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 0, 0);
    guard = 0;
    while (!(in_flight && cyc + 1 >= last_l + 2) && guard < 100) begin
      idle(1);
      guard++;
    end
    if (guard >= 100) chk("flush_wait_timeout", 1, 0);
    step(0, 8'h00, 1, 0);
    force_blen = 0;
    idle(30);
    drain();

    // randomized traffic
    repeat (400) step($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 59) == 0,
                      $urandom_range(0, 19) == 0);
    drain();

    // asynchronous reset during HOLD, then restart with the gap in place
    step(1, 8'h5A, 0, 0);
    guard = 0;
    while (!(in_flight && cyc == last_l) && guard < 100) begin
      idle(1);
      guard++;
    end
    if (guard >= 100) chk("hold_wait_timeout", 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0, 0);
    drain();

    @(negedge clk); #1;
    chk("launch_queue_empty", launch_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Buffers bytes written by the CPU to the UART data register and sequences them into the UART transmitter one at a time, so software no longer polls the TX-busy status before every write. Sits between the peripheral address decode in the top level (CPU write strobe to the UART address) and the `uart_tx` instance. It owns the `uart_tx_en`/`uart_tx_data` pair and observes `uart_tx_busy`.

## Interface
Parameters:
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 bytes. Legal range is 1..6.
- `GAP_CYCLES`, default 0: number of idle clk cycles inserted after the transmitter drops busy and before the next launch. Legal range is 0..255.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst_n`  in  1: reset. It is asynchronous and active-low.
- `wr_en`  in  1: one-cycle push strobe from the decoded CPU write.
- `wr_data`  in  8: byte to push.
- `flush`  in  1: discard all queued bytes.
- `clr_overflow`  in  1: clear the sticky overflow flag.
- `tx_busy`  in  1: busy indication from `uart_tx`.
- `tx_en`  out  1: one-cycle launch pulse to `uart_tx`.
- `tx_data`  out  8: byte for `uart_tx`. Registered.
- `full`  out  1: FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `level`  out  DEPTH_LOG2+1: current occupancy.
- `overflow`  out  1: sticky flag, set when a push is dropped because the FIFO was full.

## Operation
- Reset values: `tx_en`=0, `tx_data`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0. FSM is in IDLE, FIFO pointers are 0, gap counter is 0.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read and write pointers; pointers wrap modulo depth.
  - `level` is a separate counter. `full`/`empty` are decoded from the registered `level`.
- Push: `wr_en`=1 and `full`=0 at the edge. The byte is written at wptr, wptr increments, `level` increments.
- Full push: `wr_en`=1 while `full`=1 drops the byte and sets `overflow`. This holds even if a pop occurs in the same cycle; `full` is the value at the start of the cycle.
- Pop: occurs only on the IDLE->LAUNCH transition. `tx_data` <= mem[rptr], rptr increments, `level` decrements.
- Push and pop in the same cycle: `level` is unchanged and both pointers advance.
- Flush:
  - `flush`=1 at an edge sets rptr=wptr=0 and `level`=0.
  - A push in the same cycle is dropped and does not set overflow.
  - A byte already popped still completes. The FSM is not disturbed, and `tx_data` holds its value.
- Overflow flag:
  - `clr_overflow`=1 clears `overflow`.
  - If a set and a clear occur in the same cycle, set wins.
- FSM states:
  - IDLE: if `level`!=0 and `flush`=0, pop and go to LAUNCH; otherwise stay.
  - LAUNCH: `tx_en`=1 for exactly this cycle, then go to HOLD.
  - HOLD: one cycle in which `tx_busy` is ignored, covering the transmitter's one-cycle busy latency. Then go to WAIT_DONE.
  - WAIT_DONE: when `tx_busy`=0, go to GAP if GAP_CYCLES>0 (load counter with GAP_CYCLES), otherwise go to IDLE.
  - GAP: counter decrements each cycle; at 1, go to IDLE.
- `tx_en` is decoded from the state register (state==LAUNCH) and is glitch-free. `tx_data` is stable from LAUNCH until the next pop.
- Reset asserted mid-operation returns everything to reset values immediately. Queued bytes are lost. A frame already started in `uart_tx` is that block's concern.

## Timing
- Push to launch latency, FIFO previously empty and FSM in IDLE:
  - `wr_en` sampled at the end of cycle 0.
  - `level`=1 in cycle 1, and the pop happens at the end of cycle 1.
  - `tx_en`=1 and `tx_data` valid in cycle 2. Total latency is 2 cycles.
- Back-to-back bytes with GAP_CYCLES=0:
  - `tx_busy` is sampled low in cycle k, so the FSM is in IDLE in cycle k+1.
  - Next `tx_en` is in cycle k+2.
- With GAP_CYCLES=G, the next `tx_en` is in cycle k+2+G.
- Minimum spacing between two `tx_en` pulses is 4 cycles: LAUNCH, HOLD, one WAIT_DONE cycle, IDLE.
- `full`, `empty` and `level` update the cycle after the push, pop or flush edge.

## Configuration
- Macro `UART_TX_SCHED_OVERFLOW_EN`:
  - Defined: the `overflow` register and the `clr_overflow` logic are built as described above.
  - Undefined: `overflow` is tied to 0 and `clr_overflow` is ignored. Full-FIFO pushes are still dropped silently. All other behaviour is identical.

## Test plan
- Single byte: push 0x41 into an empty FIFO with `tx_busy` modelling 10 cycles of busy. Required: `tx_en` is high only in cycle 2, with `tx_data`=0x41. `level` is 1 in cycle 1 and 0 in cycle 2.
- Ordering and wrap: DEPTH_LOG2=3; push 0x00..0x13 (20 bytes) paced so the FIFO never fills. Required: `tx_en` pulses carry 0x00..0x13 in order, pointers wrap twice, and `overflow` stays 0.
- Overflow: hold `tx_busy`=1 and push 10 bytes into a depth-8 FIFO. Required:
  - After the pop of the first byte, 8 bytes are queued and `full`=1.
  - The 10th push is dropped and `overflow`=1.
  - `clr_overflow` clears `overflow` the next cycle.
- Simultaneous: push while `full`=1 in the IDLE->LAUNCH pop cycle. Required: the byte is dropped, `level` goes 8->7, and `overflow`=1.
- Flush: queue 5 bytes and assert `flush` during WAIT_DONE of the first byte. Required: the first byte completes, `level`=0 the next cycle, and no further `tx_en` occurs.
- Reset and gap: GAP_CYCLES=3; assert `rst_n`=0 asynchronously mid-HOLD. Required: `tx_en`=0 and `level`=0 immediately. After release, a new push launches with 2-cycle latency, and consecutive launches are separated by `tx_busy` falling plus 2+3 cycles.
